aes_frame_tx: RTL and testbench
===============================

AES_FRAME_TX -- requirements
Module: aes_frame_tx

Interface
REQ-001 Parameter IDLE_GAP, default 2, meaning number of en ticks held idle between consecutive frames (0 allowed).
REQ-002 Parameter FRAME_BYTES, default 16, meaning payload bytes per frame (fixed 16; other values unsupported).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 en  input  1  one-cycle byte-rate tick from clock divider.
REQ-006 data  input  128  head word of first-word-fall-through FIFO, valid whenever empty=0.
REQ-007 empty  input  1  FIFO empty flag.
REQ-008 require  output  1  one-cycle FIFO pop strobe.
REQ-009 shakehand  output  1  toggles once per byte sent; chip samples tx on each toggle.
REQ-010 tx  output  8  byte lane to chip.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 frames_sent  output  32  count of completed frames, wraps 0xFFFFFFFF->0.

Function
REQ-013 FSM states IDLE, SEND, CHK, GAP; encoding free.
REQ-014 IDLE: if empty=0, assert require for exactly one cycle, latch data into 128-bit shift register, clear byte index, go SEND next cycle.
REQ-015 require never asserted while empty=1 nor outside IDLE.
REQ-016 en coincident with the latch cycle is ignored; first byte goes out on the first en seen in SEND.
REQ-017 SEND: on each en, tx <= current byte (data[127:120] first, data[7:0] last), shakehand inverts, index increments, in the same edge.
REQ-018 tx and shakehand hold their values between en ticks and after frame end.
REQ-019 After byte index 15 is sent: go CHK if AES_TX_PARITY_EN is defined, else GAP; frames_sent increments on that same edge.
REQ-020 GAP: count IDLE_GAP en ticks, then IDLE; IDLE_GAP=0 returns to IDLE on the next clock without waiting for en.
REQ-021 Byte-to-byte spacing equals en period; latency from require to first shakehand toggle is 1 to (1 + en period) cycles.
REQ-022 data/empty changes while busy are ignored; the latched word is sent intact.
REQ-023 busy=1 from the cycle after require through the last GAP cycle.

Reset
REQ-024 rst_n=0 forces, asynchronously: state IDLE, require=0, shakehand=0, tx=8'h00, busy=0, frames_sent=0, index and gap counter 0, shift register 0.
REQ-025 Reset mid-frame aborts the frame without completing it; no pop occurs until reset is released and empty=0 is seen in IDLE.

Configuration
REQ-026 Macro AES_TX_PARITY_EN defined: CHK state sends one extra byte on the next en = XOR of the 16 payload bytes, with shakehand toggle (17 toggles per frame), then GAP.
REQ-027 AES_TX_PARITY_EN undefined: CHK state and XOR logic absent; 16 toggles per frame.

Structure
REQ-028 Shared package aes_platform_pkg holds the FSM state typedef, AES_BLOCK_W=128, AES_BYTE_W=8, and FRAME_BYTES default.
REQ-029 One sub-module, aes_frame_parity (running 8-bit XOR accumulator with clear/enable), instantiated only under AES_TX_PARITY_EN.

Verification
REQ-030 Single frame: FIFO holds 128'h000102...0E0F, en every 4 cycles -> one require pulse, 16 toggles, tx sequence 00,01,...,0F, frames_sent=1, busy low after 2 gap ticks.
REQ-031 Back-to-back: 3 words queued, IDLE_GAP=2 -> exactly 3 require pulses, 48 toggles, 2 en ticks with no toggle between frames, frames_sent=3.
REQ-032 Empty FIFO: empty=1 for 1000 cycles with en running -> require, shakehand, tx unchanged from reset values, busy=0.
REQ-033 Reset mid-frame: assert rst_n=0 after byte 7 -> all outputs at reset values in the same cycle, frames_sent=0, next frame restarts at byte 0.
REQ-034 Parity build, payload 128'hFF00...00 -> 17th byte = 8'hFF; payload all 8'hA5 -> 17th byte = 8'h00.
REQ-035 Wrap: preload frames_sent=0xFFFFFFFF by force, send one frame -> frames_sent=0.

Source files
------------

// File: rtl/aes_platform_pkg.sv
// rtl/aes_platform_pkg.sv - shared widths, frame size and transmitter state type
`timescale 1ns/1ps
package aes_platform_pkg;

  localparam int AES_BLOCK_W     = 128;
  localparam int AES_BYTE_W      = 8;
  localparam int AES_FRAME_BYTES = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_CHK,
    ST_GAP
  } tx_state_t;

endpackage

// File: rtl/aes_frame_parity.sv
// rtl/aes_frame_parity.sv - running 8-bit XOR accumulator over sent payload bytes
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : zero the accumulator (takes priority over en)
//   en         : fold din into the accumulator
//   din        : byte being sent
//   acc        : XOR of all bytes folded since the last clear
`timescale 1ns/1ps
module aes_frame_parity
  import aes_platform_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  en,
  input  logic [AES_BYTE_W-1:0] din,
  output logic [AES_BYTE_W-1:0] acc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc ^ din;
    end
  end

endmodule

// File: rtl/aes_frame_tx.sv
// rtl/aes_frame_tx.sv - pops 128-bit words from a FWFT FIFO and sends them bytewise on en ticks
//   clk, rst_n  : clock, asynchronous active-low reset
//   en          : byte-rate tick
//   data, empty : FIFO head word and empty flag
//   require     : one-cycle FIFO pop strobe
//   shakehand   : toggles once per byte; tx is valid on each toggle
//   tx          : byte lane, MSB byte of the word first
//   busy        : high whenever not idle
//   frames_sent : completed frame count, wraps
//   Optional macro AES_TX_PARITY_EN appends an XOR check byte to each frame.
`timescale 1ns/1ps
module aes_frame_tx
  import aes_platform_pkg::*;
#(
  parameter int IDLE_GAP    = 2,
  parameter int FRAME_BYTES = AES_FRAME_BYTES
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [AES_BLOCK_W-1:0] data,
  input  logic                   empty,
  output logic                   require,
  output logic                   shakehand,
  output logic [AES_BYTE_W-1:0]  tx,
  output logic                   busy,
  output logic [31:0]            frames_sent
);

  localparam int IDX_W    = $clog2(FRAME_BYTES);
  localparam int GAP_LAST = (IDLE_GAP > 0) ? IDLE_GAP - 1 : 0;
  localparam int GAP_W    = (GAP_LAST > 0) ? $clog2(GAP_LAST + 1) : 1;

  tx_state_t              state;
  logic [AES_BLOCK_W-1:0] shreg;
  logic [IDX_W-1:0]       idx;
  logic [GAP_W-1:0]       gap_cnt;
  logic [AES_BYTE_W-1:0]  head_byte;

  assign head_byte = shreg[AES_BLOCK_W-1 -: AES_BYTE_W];

  // The pop strobe is a decode of IDLE with a non-empty FIFO: the word is
  // latched on the same edge the FIFO pops, so the strobe lasts exactly one
  // cycle and busy rises the cycle after. Gated by rst_n so no pop can occur
  // while reset is held.
  assign require = rst_n && (state == ST_IDLE) && !empty;

`ifdef AES_TX_PARITY_EN
  logic [AES_BYTE_W-1:0] parity;

  aes_frame_parity u_parity (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (require),
    .en    ((state == ST_SEND) && en),
    .din   (head_byte),
    .acc   (parity)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      shreg       <= '0;
      idx         <= '0;
      gap_cnt     <= '0;
      shakehand   <= 1'b0;
      tx          <= '0;
      busy        <= 1'b0;
      frames_sent <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          // en in this cycle is deliberately not consumed.
          if (!empty) begin
            shreg <= data;
            idx   <= '0;
            busy  <= 1'b1;
            state <= ST_SEND;
          end
        end

        ST_SEND: begin
          if (en) begin
            tx        <= head_byte;
            shreg     <= {shreg[AES_BLOCK_W-AES_BYTE_W-1:0], {AES_BYTE_W{1'b0}}};
            shakehand <= ~shakehand;
            idx       <= idx + IDX_W'(1);
            if (idx == IDX_W'(FRAME_BYTES - 1)) begin
              frames_sent <= frames_sent + 32'd1;
              gap_cnt     <= '0;
`ifdef AES_TX_PARITY_EN
              state       <= ST_CHK;
`else
              state       <= ST_GAP;
`endif
            end
          end
        end

`ifdef AES_TX_PARITY_EN
        ST_CHK: begin
          if (en) begin
            tx        <= parity;
            shakehand <= ~shakehand;
            state     <= ST_GAP;
          end
        end
`endif

        ST_GAP: begin
          if (IDLE_GAP == 0) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else if (en) begin
            if (gap_cnt == GAP_W'(GAP_LAST)) begin
              busy  <= 1'b0;
              state <= ST_IDLE;
            end else begin
              gap_cnt <= gap_cnt + GAP_W'(1);
            end
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_frame_tx.sv
// tb/tb_aes_frame_tx.sv - directed self-checking bench for aes_frame_tx
`timescale 1ns/1ps
module tb_aes_frame_tx;

`ifdef AES_TX_PARITY_EN
  localparam int TOG = 17;
`else
  localparam int TOG = 16;
`endif

  logic         clk;
  logic         rst_n;
  logic         en;
  logic [127:0] data;
  logic         empty;
  logic         require;
  logic         shakehand;
  logic [7:0]   tx;
  logic         busy;
  logic [31:0]  frames_sent;

  aes_frame_tx #(.IDLE_GAP(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .data        (data),
    .empty       (empty),
    .require     (require),
    .shakehand   (shakehand),
    .tx          (tx),
    .busy        (busy),
    .frames_sent (frames_sent)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // en: one-cycle tick every 4 clocks while en_run is set
  logic en_run;
  int   ph;
  initial begin
    en = 1'b0;
    ph = 0;
    forever begin
      @(posedge clk);
      #1;
      en = en_run && (ph == 0);
      ph = (ph == 3) ? 0 : ph + 1;
    end
  end

  // FWFT FIFO model: words pushed by the main block, popped by require pulses
  logic [127:0] words [0:15];
  int           n_pushed;
  int           req_cnt;
  initial begin
    data  = '0;
    empty = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      empty = (req_cnt >= n_pushed);
      data  = (empty || req_cnt > 15) ? 128'h0 : words[req_cnt];
    end
  end

  // Monitor: require pulses, byte log on each shakehand toggle, gap en ticks
  int         tog_cnt;
  logic [7:0] tx_log [0:255];
  int         gap_log [0:15];
  int         gap_n;
  logic       sh_prev;
  logic [31:0] fs_prev;
  logic       in_gap;
  int         gap_ticks;
  initial begin
    req_cnt = 0; tog_cnt = 0; gap_n = 0; sh_prev = 1'b0; fs_prev = '0;
    in_gap = 1'b0; gap_ticks = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_gap    = 1'b0;
        gap_ticks = 0;
      end else begin
        if (require) req_cnt++;
        if (shakehand !== sh_prev) begin
          if (tog_cnt < 256) tx_log[tog_cnt] = tx;
          tog_cnt++;
        end
        if (in_gap && busy && en) gap_ticks++;
        if (frames_sent !== fs_prev) begin
          in_gap    = 1'b1;
          gap_ticks = 0;
        end
        if (in_gap && !busy) begin
          if (gap_n < 16) gap_log[gap_n] = gap_ticks;
          gap_n++;
          in_gap = 1'b0;
        end
      end
      sh_prev = shakehand;
      fs_prev = frames_sent;
    end
  end

  int n_checks;
  int n_fail;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [127:0] w);
    words[n_pushed] = w;
    n_pushed++;
  endtask

  task automatic wait_frames(input logic [31:0] target);
    int n = 0;
    while (frames_sent !== target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("wait_frames", frames_sent, target);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("wait_idle", busy, 1'b0);
  endtask

  task automatic wait_toggles(input int target);
    int n = 0;
    while (tog_cnt < target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("wait_toggles", tog_cnt, target);
  endtask

  task automatic check_frame(input string tag, input int base, input logic [127:0] w);
    for (int i = 0; i < 16; i++) begin
      check(tag, tx_log[base + i], w[127 - 8*i -: 8]);
    end
  endtask

  logic [127:0] w_seq, w_a, w_b, w_c, w_r1, w_r2, w_wrap;
  int req_base, tog_base, gap_base;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    n_pushed = 0;
    en_run   = 1'b0;
    rst_n    = 1'b0;
    w_seq  = 128'h000102030405060708090A0B0C0D0E0F;
    w_a    = 128'hDEADBEEF0123456789ABCDEFCAFEF00D;
    w_b    = 128'hFFEEDDCCBBAA99887766554433221100;
    w_c    = 128'h5A5A5A5AA5A5A5A50F0F0F0FF0F0F0F0;
    w_r1   = 128'h112233445566778899AABBCCDDEEFF00;
    w_r2   = 128'hC0C1C2C3C4C5C6C7C8C9CACBCCCDCECF;
    w_wrap = 128'h0123456789ABCDEF0123456789ABCDEF;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_require", require, 1'b0);
    check("rst_shakehand", shakehand, 1'b0);
    check("rst_tx", tx, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_frames", frames_sent, 32'h0);

    // Empty FIFO with en running for 1000 cycles
    rst_n  = 1'b1;
    en_run = 1'b1;
    req_base = req_cnt;
    tog_base = tog_cnt;
    repeat (1000) @(negedge clk);
    check("empty_req_pulses", req_cnt - req_base, 0);
    check("empty_toggles", tog_cnt - tog_base, 0);
    check("empty_shakehand", shakehand, 1'b0);
    check("empty_tx", tx, 8'h00);
    check("empty_busy", busy, 1'b0);

    // Single frame
    req_base = req_cnt; tog_base = tog_cnt; gap_base = gap_n;
    push(w_seq);
    wait_frames(32'd1);
    wait_idle();
    repeat (2) @(negedge clk);
    check("single_req_pulses", req_cnt - req_base, 1);
    check("single_toggles", tog_cnt - tog_base, TOG);
    check_frame("single_byte", tog_base, w_seq);
    check("single_gap_ticks", gap_log[gap_base], 2);
    check("single_frames", frames_sent, 32'd1);
    check("single_busy", busy, 1'b0);

    // Back-to-back: three queued words
    req_base = req_cnt; tog_base = tog_cnt; gap_base = gap_n;
    push(w_a);
    push(w_b);
    push(w_c);
    wait_frames(32'd4);
    wait_idle();
    repeat (2) @(negedge clk);
    check("b2b_req_pulses", req_cnt - req_base, 3);
    check("b2b_toggles", tog_cnt - tog_base, 3 * TOG);
    check_frame("b2b_frame0", tog_base, w_a);
    check_frame("b2b_frame1", tog_base + TOG, w_b);
    check_frame("b2b_frame2", tog_base + 2 * TOG, w_c);
    check("b2b_gap0", gap_log[gap_base], 2);
    check("b2b_gap1", gap_log[gap_base + 1], 2);
    check("b2b_gap2", gap_log[gap_base + 2], 2);
    check("b2b_frames", frames_sent, 32'd4);

    // Reset mid-frame after byte 7
    tog_base = tog_cnt;
    push(w_r1);
    wait_toggles(tog_base + 8);
    check("mid_busy_before", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_require", require, 1'b0);
    check("mid_rst_shakehand", shakehand, 1'b0);
    check("mid_rst_tx", tx, 8'h00);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_frames", frames_sent, 32'h0);
    @(negedge clk);
    req_base = req_cnt;
    push(w_r2);
    repeat (4) @(negedge clk);
    check("mid_hold_require", require, 1'b0);
    check("mid_hold_pulses", req_cnt - req_base, 0);
    tog_base = tog_cnt;
    rst_n = 1'b1;
    wait_frames(32'd1);
    wait_idle();
    check("mid_restart_toggles", tog_cnt - tog_base, TOG);
    check("mid_restart_first", tx_log[tog_base], 8'hC0);
    check("mid_restart_last", tx_log[tog_base + 15], 8'hCF);
    check("mid_restart_pulses", req_cnt - req_base, 1);

`ifdef AES_TX_PARITY_EN
    // Check byte = XOR of payload bytes
    tog_base = tog_cnt;
    push(128'hFF000000000000000000000000000000);
    push({16{8'hA5}});
    wait_frames(32'd3);
    wait_idle();
    check("par_toggles", tog_cnt - tog_base, 34);
    check("par_ff", tx_log[tog_base + 16], 8'hFF);
    check("par_a5", tx_log[tog_base + 33], 8'h00);
`endif

    // Counter wrap
    @(negedge clk);
    force dut.frames_sent = 32'hFFFFFFFF;
    @(negedge clk);
    release dut.frames_sent;
    @(negedge clk);
    check("wrap_preload", frames_sent, 32'hFFFFFFFF);
    push(w_wrap);
    wait_frames(32'h0);
    wait_idle();
    check("wrap_frames", frames_sent, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
